// File: rtl/pio_sample_poller.sv
// Avalon-MM read master that polls a 16-bit PIO at a fixed period, averages
// 2**AVG_LOG2 signed samples and presents each average on a valid/ready port.
module pio_sample_poller #(
    parameter int         PERIOD     = 1000,
    parameter int         AVG_LOG2   = 2,
    parameter int         RD_LATENCY = 1,
    parameter logic [1:0] PIO_ADDR   = 2'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overrun,
    input  logic        clear_overrun,
    output logic        busy
);
    localparam int              SUM_W     = 16 + AVG_LOG2;
    localparam int              CNT_W     = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [15:0]     LAST_TICK = 16'(PERIOD - 1);
    localparam logic [1:0]      LAT_LAST  = 2'(RD_LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACC  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       per_cnt_q, per_cnt_d;
    logic              pend_q, pend_d;
    logic [1:0]        lat_q, lat_d;
    logic [15:0]       sample_q, sample_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              overrun_q, overrun_d;
    logic              avm_read_q, avm_read_d;
    logic              busy_q, busy_d;
    logic              tick_s;
    logic              load_s;
    logic              xfer_s;
    logic [SUM_W-1:0]  sum_next_s;
    logic              unused_hi_s;

    // Sign-extend a raw PIO sample to the accumulator width.
    function automatic logic [SUM_W-1:0] sext_sample(input logic [15:0] v);
        return SUM_W'($signed(v));
    endfunction

    assign avm_address = PIO_ADDR;
    assign avm_read    = avm_read_q;
    assign busy        = busy_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign overrun     = overrun_q;
    assign unused_hi_s = ^avm_readdata[31:16];
    assign tick_s      = enable && (per_cnt_q == LAST_TICK);
    assign xfer_s      = out_valid_q && out_ready;

    // Period counter, pending-read flag and read/accumulate state machine.
    always_comb begin
        state_d    = state_q;
        per_cnt_d  = per_cnt_q;
        pend_d     = pend_q;
        lat_d      = lat_q;
        sample_d   = sample_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        load_s     = 1'b0;
        sum_next_s = sum_q + sext_sample(sample_q);

        // A disabled poller issues at once when re-enabled; a period tick
        // that lands mid-transaction is remembered as one pending read.
        if (!enable) begin
            per_cnt_d = 16'd0;
            pend_d    = 1'b1;
        end else if (tick_s) begin
            per_cnt_d = 16'd0;
            pend_d    = 1'b1;
        end else begin
            per_cnt_d = per_cnt_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable && (tick_s || pend_q)) begin
                    state_d   = ST_REQ;
                    per_cnt_d = 16'd0;
                    pend_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!avm_waitrequest) begin
                    state_d = ST_WAIT;
                    lat_d   = 2'd1;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    sample_d = avm_readdata[15:0];
                    state_d  = ST_ACC;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            ST_ACC: begin
                state_d = ST_IDLE;
                if (cnt_q == LAST_CNT) begin
                    load_s = 1'b1;
                    sum_d  = {SUM_W{1'b0}};
                    cnt_d  = {CNT_W{1'b0}};
                end else begin
                    sum_d = sum_next_s;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        avm_read_d = (state_d == ST_REQ);
        busy_d     = (state_d == ST_REQ) || (state_d == ST_WAIT);
    end

    // Output register, valid/ready handshake and sticky overrun flag.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        if (load_s) begin
            out_data_d  = sum_next_s[AVG_LOG2 +: 16];
            out_valid_d = 1'b1;
        end else if (xfer_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (clear_overrun) begin
            overrun_d = 1'b0;
        end else if (load_s && out_valid_q && !out_ready) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            per_cnt_q   <= 16'd0;
            pend_q      <= 1'b1;
            lat_q       <= 2'd0;
            sample_q    <= 16'd0;
            sum_q       <= {SUM_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            out_data_q  <= 16'd0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            avm_read_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            per_cnt_q   <= per_cnt_d;
            pend_q      <= pend_d;
            lat_q       <= lat_d;
            sample_q    <= sample_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            avm_read_q  <= avm_read_d;
            busy_q      <= busy_d;
        end
    end
endmodule
